el2_lsu_dccm_arb: RTL
=====================

Name: el2_lsu_dccm_arb

Overview:
- Sequences the single-ported, banked DCCM among three requesters: the LSU pipe (load/store), the store-buffer drain, and the DMA slave port.
- Issues at most one DCCM access per cycle as a lo/hi address pair, with read data returned one cycle after issue.
- Starvation counters and a store-buffer-full urgency override guarantee forward progress for the lower-priority requesters.

Parameters:
- DCCM_BITS, 16, DCCM byte-address width.
- DCCM_FDATA_WIDTH, 39, bank data width including ECC.
- STARVE_MAX, 15, cycles a requester may wait before it is force-granted; counter width is $clog2(STARVE_MAX+1).

Ports:
- clk  in  1  free-running core clock
- rst_l  in  1  reset, asynchronous, active-low
- lsu_req  in  1  LSU pipe access request
- lsu_wr  in  1  1=write, 0=read
- lsu_addr_lo, lsu_addr_hi  in  DCCM_BITS  lo/hi addresses; differ in bank bits when misaligned
- lsu_wdata_lo, lsu_wdata_hi  in  DCCM_FDATA_WIDTH  write data
- lsu_gnt  out  1  LSU access issued this cycle
- lsu_stall  out  1  lsu_req & ~lsu_gnt
- sb_req  in  1  store-buffer drain request (write only)
- sb_full  in  1  store buffer full; urgency override
- sb_addr_lo, sb_addr_hi  in  DCCM_BITS  drain addresses
- sb_wdata_lo, sb_wdata_hi  in  DCCM_FDATA_WIDTH  drain data
- sb_gnt  out  1  drain issued
- dma_req  in  1  DMA request; always aligned
- dma_wr  in  1  1=write
- dma_addr  in  DCCM_BITS  DMA address
- dma_wdata  in  DCCM_FDATA_WIDTH  DMA write data
- dma_gnt  out  1  DMA issued
- dccm_wren, dccm_rden  out  1  to the DCCM memory block
- dccm_wr_addr_lo, dccm_wr_addr_hi, dccm_rd_addr_lo, dccm_rd_addr_hi  out  DCCM_BITS  memory addresses
- dccm_wr_data_lo, dccm_wr_data_hi  out  DCCM_FDATA_WIDTH  memory write data
- dccm_rd_data_lo, dccm_rd_data_hi  in  DCCM_FDATA_WIDTH  memory read data, valid the cycle after dccm_rden
- lsu_rd_valid, dma_rd_valid  out  1  read-return pulse for the owner
- rd_data_lo, rd_data_hi  out  DCCM_FDATA_WIDTH  forwarded dccm_rd_data_*

Behaviour:
- Grants are combinational, same cycle as the request; onehot0 across lsu_gnt, sb_gnt, dma_gnt. A gnt requires its req.
- Priority, first match wins:
  1. dma_req & dma_cnt==STARVE_MAX
  2. sb_req & (sb_full | sb_cnt==STARVE_MAX)
  3. lsu_req
  4. sb_req
  5. dma_req
- Starvation counters sb_cnt and dma_cnt, per cycle:
  - reset to 0 when req=0 or gnt=1;
  - otherwise increment, saturating at STARVE_MAX.
  - Each counter is a registered value used combinationally next cycle.
- Memory drive:
  - Write grant: dccm_wren=1; wr_addr/wr_data taken from the winner.
  - Read grant: dccm_rden=1; rd_addr taken from the winner.
  - DMA grant drives hi = lo (address and data).
  - Unused address/data outputs and all outputs when idle are 0; dccm_wren and dccm_rden are never both 1.
- Read return pipeline:
  - Registered owner flags lsu_rd_q and dma_rd_q, set when a read is granted to that owner.
  - lsu_rd_valid = lsu_rd_q, dma_rd_valid = dma_rd_q; both 1-cycle pulses, fixed latency 1.
  - rd_data_lo/hi = dccm_rd_data_lo/hi, passed through unregistered.
- Back-to-back reads to alternating owners: one grant per cycle, each valid one cycle after its grant.
- Reset (asynchronous assert, synchronous deassert via rst_l):
  - counters=0, lsu_rd_q=0, dma_rd_q=0.
  - All gnt, wren, rden outputs are 0 while rst_l=0.
  - A read in flight at reset assertion produces no valid pulse.
- Requesters hold req and payload stable until gnt; the arbiter does not latch payloads.

Test Plan:
- Reset: rst_l=0 with all reqs=1 -> all gnt=0, dccm_wren=dccm_rden=0, rd_valid=0; release -> first cycle lsu_gnt=1.
- LSU read at addr_lo=0x0104, addr_hi=0x0108 -> dccm_rden=1 with those addresses; next cycle lsu_rd_valid=1, dma_rd_valid=0, rd_data = memory data.
- lsu_req held at 1 with dma_req at 1 -> dma_gnt=0 for 15 cycles; 16th cycle dma_gnt=1, lsu_stall=1, dma_cnt returns to 0; following cycle lsu_gnt=1.
- sb_full=1 with lsu_req=1 and sb_req=1 -> sb_gnt=1, dccm_wren=1, lsu_stall=1; sb_full=0 -> lsu_gnt=1.
- DMA write only, addr=0x0200, data=0x12_3456_789A -> wr_addr_lo=wr_addr_hi=0x0200, wr_data_hi=wr_data_lo, dccm_rden=0.
- Alternating LSU and DMA reads on consecutive cycles -> lsu_rd_valid and dma_rd_valid alternate, each exactly one cycle after its grant; no two grants in one cycle (onehot0 assertion).

Source files
------------

// File: rtl/el2_lsu_dccm_arb.sv
// DCCM port arbiter: one access per cycle among LSU pipe, store-buffer drain and DMA,
// with starvation counters and a one-cycle read-return owner pipeline.
module el2_lsu_dccm_arb #(
    parameter int unsigned DCCM_BITS        = 16,
    parameter int unsigned DCCM_FDATA_WIDTH = 39,
    parameter int unsigned STARVE_MAX       = 15
) (
    input  logic                        clk,
    input  logic                        rst_l,

    input  logic                        lsu_req,
    input  logic                        lsu_wr,
    input  logic [DCCM_BITS-1:0]        lsu_addr_lo,
    input  logic [DCCM_BITS-1:0]        lsu_addr_hi,
    input  logic [DCCM_FDATA_WIDTH-1:0] lsu_wdata_lo,
    input  logic [DCCM_FDATA_WIDTH-1:0] lsu_wdata_hi,
    output logic                        lsu_gnt,
    output logic                        lsu_stall,

    input  logic                        sb_req,
    input  logic                        sb_full,
    input  logic [DCCM_BITS-1:0]        sb_addr_lo,
    input  logic [DCCM_BITS-1:0]        sb_addr_hi,
    input  logic [DCCM_FDATA_WIDTH-1:0] sb_wdata_lo,
    input  logic [DCCM_FDATA_WIDTH-1:0] sb_wdata_hi,
    output logic                        sb_gnt,

    input  logic                        dma_req,
    input  logic                        dma_wr,
    input  logic [DCCM_BITS-1:0]        dma_addr,
    input  logic [DCCM_FDATA_WIDTH-1:0] dma_wdata,
    output logic                        dma_gnt,

    output logic                        dccm_wren,
    output logic                        dccm_rden,
    output logic [DCCM_BITS-1:0]        dccm_wr_addr_lo,
    output logic [DCCM_BITS-1:0]        dccm_wr_addr_hi,
    output logic [DCCM_BITS-1:0]        dccm_rd_addr_lo,
    output logic [DCCM_BITS-1:0]        dccm_rd_addr_hi,
    output logic [DCCM_FDATA_WIDTH-1:0] dccm_wr_data_lo,
    output logic [DCCM_FDATA_WIDTH-1:0] dccm_wr_data_hi,
    input  logic [DCCM_FDATA_WIDTH-1:0] dccm_rd_data_lo,
    input  logic [DCCM_FDATA_WIDTH-1:0] dccm_rd_data_hi,

    output logic                        lsu_rd_valid,
    output logic                        dma_rd_valid,
    output logic [DCCM_FDATA_WIDTH-1:0] rd_data_lo,
    output logic [DCCM_FDATA_WIDTH-1:0] rd_data_hi
);

    localparam int unsigned CNT_W = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

    logic [CNT_W-1:0] sb_cnt_q, sb_cnt_d;
    logic [CNT_W-1:0] dma_cnt_q, dma_cnt_d;
    logic             lsu_rd_q, dma_rd_q;
    logic             dma_urgent, sb_urgent;

    assign dma_urgent = dma_req & (dma_cnt_q == CNT_MAX);
    assign sb_urgent  = sb_req & (sb_full | (sb_cnt_q == CNT_MAX));

    // Grants are suppressed while reset is held so nothing reaches the memory.
    always_comb begin
        lsu_gnt = 1'b0;
        sb_gnt  = 1'b0;
        dma_gnt = 1'b0;
        if (rst_l) begin
            if (dma_urgent)     dma_gnt = 1'b1;
            else if (sb_urgent) sb_gnt  = 1'b1;
            else if (lsu_req)   lsu_gnt = 1'b1;
            else if (sb_req)    sb_gnt  = 1'b1;
            else if (dma_req)   dma_gnt = 1'b1;
        end
    end

    assign lsu_stall = lsu_req & ~lsu_gnt;

    always_comb begin
        dccm_wren       = 1'b0;
        dccm_rden       = 1'b0;
        dccm_wr_addr_lo = '0;
        dccm_wr_addr_hi = '0;
        dccm_rd_addr_lo = '0;
        dccm_rd_addr_hi = '0;
        dccm_wr_data_lo = '0;
        dccm_wr_data_hi = '0;
        if (lsu_gnt) begin
            if (lsu_wr) begin
                dccm_wren       = 1'b1;
                dccm_wr_addr_lo = lsu_addr_lo;
                dccm_wr_addr_hi = lsu_addr_hi;
                dccm_wr_data_lo = lsu_wdata_lo;
                dccm_wr_data_hi = lsu_wdata_hi;
            end else begin
                dccm_rden       = 1'b1;
                dccm_rd_addr_lo = lsu_addr_lo;
                dccm_rd_addr_hi = lsu_addr_hi;
            end
        end else if (sb_gnt) begin
            dccm_wren       = 1'b1;
            dccm_wr_addr_lo = sb_addr_lo;
            dccm_wr_addr_hi = sb_addr_hi;
            dccm_wr_data_lo = sb_wdata_lo;
            dccm_wr_data_hi = sb_wdata_hi;
        end else if (dma_gnt) begin
            // DMA is always aligned, so both halves carry the same address and data.
            if (dma_wr) begin
                dccm_wren       = 1'b1;
                dccm_wr_addr_lo = dma_addr;
                dccm_wr_addr_hi = dma_addr;
                dccm_wr_data_lo = dma_wdata;
                dccm_wr_data_hi = dma_wdata;
            end else begin
                dccm_rden       = 1'b1;
                dccm_rd_addr_lo = dma_addr;
                dccm_rd_addr_hi = dma_addr;
            end
        end
    end

    always_comb begin
        sb_cnt_d  = sb_cnt_q;
        dma_cnt_d = dma_cnt_q;
        if (!sb_req || sb_gnt)        sb_cnt_d = '0;
        else if (sb_cnt_q != CNT_MAX) sb_cnt_d = sb_cnt_q + CNT_W'(1);
        if (!dma_req || dma_gnt)       dma_cnt_d = '0;
        else if (dma_cnt_q != CNT_MAX) dma_cnt_d = dma_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            sb_cnt_q  <= '0;
            dma_cnt_q <= '0;
            lsu_rd_q  <= 1'b0;
            dma_rd_q  <= 1'b0;
        end else begin
            sb_cnt_q  <= sb_cnt_d;
            dma_cnt_q <= dma_cnt_d;
            lsu_rd_q  <= lsu_gnt & ~lsu_wr;
            dma_rd_q  <= dma_gnt & ~dma_wr;
        end
    end

    assign lsu_rd_valid = lsu_rd_q;
    assign dma_rd_valid = dma_rd_q;
    assign rd_data_lo   = dccm_rd_data_lo;
    assign rd_data_hi   = dccm_rd_data_hi;

endmodule
